// File: rtl/pipeline_stall_controller_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
// Provides the FSM state encoding, parameter defaults and the stage-control bundle.
// The freeze/normal helpers give the two baseline control patterns that events modify.
package pipeline_stall_controller_pkg;

    localparam int REG_W_DEF       = 5;
    localparam int CNT_W_DEF       = 16;
    localparam int MEM_TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_ERROR    = 2'd3
    } state_e;

    // One enable/clear per pipeline register boundary.
    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_bubble;
        logic ex_mem_write;
        logic mem_wb_bubble;
    } stage_ctrl_t;

    // Whole pipeline holds; MEM/WB gets a NOP so a held access does not retire twice.
    function automatic stage_ctrl_t ctrl_freeze();
        stage_ctrl_t c;
        c               = '0;
        c.mem_wb_bubble = 1'b1;
        return c;
    endfunction

    // Every stage advances, nothing squashed.
    function automatic stage_ctrl_t ctrl_normal();
        stage_ctrl_t c;
        c              = '0;
        c.pc_write     = 1'b1;
        c.if_id_write  = 1'b1;
        c.ex_mem_write = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/pipeline_stall_controller_wait_timer.sv
// stall_wait_timer: counts consecutive data-memory wait cycles, flags when the limit is reached.
// Ports: clk_i/rst_i (async active-high), clr_i (priority) and inc_i controls, expired_o flag.
// Saturates at MEM_TIMEOUT so the count never wraps; expired_o is a pure decode of the count.
module stall_wait_timer #(
    parameter int MEM_TIMEOUT = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam int TMR_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] LIMIT = TMR_W'(MEM_TIMEOUT);

    logic [TMR_W-1:0] count_q;
    logic [TMR_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != LIMIT)) begin
            count_d = count_q + TMR_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == LIMIT);

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer: merges memory wait, load-use interlock and taken-branch flush.
// Ports: start/hazard/branch/memory handshake in; PC and stage enables, timeout flag, stall count out.
// Stage controls are Mealy (state + current inputs); a hung memory traps into a sticky ERROR.
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int REG_W       = REG_W_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             ex_memread_i,
    input  logic [REG_W-1:0] ex_rd_i,
    input  logic [REG_W-1:0] id_rs1_i,
    input  logic [REG_W-1:0] id_rs2_i,
    input  logic             id_br_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ready_i,
    output logic             pc_write_o,
    output logic             if_id_write_o,
    output logic             if_id_flush_o,
    output logic             id_ex_bubble_o,
    output logic             ex_mem_write_o,
    output logic             mem_wb_bubble_o,
    output logic             mem_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    state_e           state_q, state_d;
    logic             mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    stage_ctrl_t      ctrl;

    logic mem_stall;
    logic load_use;
    logic tmr_clr;
    logic tmr_inc;
    logic tmr_expired;

    assign mem_stall = mem_req_i && !mem_ready_i;
    // x0 is hardwired zero, so a load to it never creates a real dependency.
    assign load_use  = ex_memread_i && (ex_rd_i != '0) &&
                       ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));

    // Timer sits at zero in RUN, so the increment on entry lands it at 1.
    assign tmr_inc = ((state_q == ST_RUN) && mem_stall) ||
                     ((state_q == ST_MEM_WAIT) && !mem_ready_i);
    assign tmr_clr = (state_q == ST_MEM_WAIT) ? mem_ready_i : !tmr_inc;

    stall_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (tmr_clr),
        .inc_i     (tmr_inc),
        .expired_o (tmr_expired)
    );

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d       = state_q;
        mem_timeout_d = mem_timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (mem_stall) state_d = ST_MEM_WAIT;
            end
            ST_MEM_WAIT: begin
                // mem_req_i is deliberately ignored here: once waiting, only ready releases.
                if (mem_ready_i) begin
                    state_d = ST_RUN;
                end else if (tmr_expired) begin
                    state_d       = ST_ERROR;
                    mem_timeout_d = 1'b1;
                end
            end
            default: state_d = ST_ERROR;
        endcase
    end

    // Output logic: priority mux over the baseline patterns.
    always_comb begin
        ctrl = ctrl_freeze();
        case (state_q)
            ST_RUN: begin
                if (!mem_stall) begin
                    ctrl = ctrl_normal();
                    if (load_use) begin
                        // Branch is not acted on here; it is re-presented after the bubble.
                        ctrl.pc_write     = 1'b0;
                        ctrl.if_id_write  = 1'b0;
                        ctrl.id_ex_bubble = 1'b1;
                    end else if (id_br_taken_i) begin
                        ctrl.if_id_flush = 1'b1;
                    end
                end
            end
            ST_MEM_WAIT: begin
                // Release cycle only advances; hazards are evaluated from the next cycle on.
                if (mem_ready_i) ctrl = ctrl_normal();
            end
            default: ctrl = ctrl_freeze();
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (((state_q == ST_RUN) || (state_q == ST_MEM_WAIT)) && !ctrl.pc_write &&
            (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_timeout_q <= 1'b0;
            stall_cnt_q   <= '0;
        end else begin
            mem_timeout_q <= mem_timeout_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign pc_write_o      = ctrl.pc_write;
    assign if_id_write_o   = ctrl.if_id_write;
    assign if_id_flush_o   = ctrl.if_id_flush;
    assign id_ex_bubble_o  = ctrl.id_ex_bubble;
    assign ex_mem_write_o  = ctrl.ex_mem_write;
    assign mem_wb_bubble_o = ctrl.mem_wb_bubble;
    assign mem_timeout_o   = mem_timeout_q;
    assign stall_cnt_o     = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Testbench for pipeline_stall_controller: directed vector table, corner sequences, random vs model.
// Inputs are driven 1 time unit after the rising edge and outputs are sampled on the falling edge.
// The DUT uses CNT_W=4 and MEM_TIMEOUT=4 so saturation and timeout are reachable quickly.
module tb_pipeline_stall_controller;

    localparam int REG_W = 5;
    localparam int CNT_W = 4;
    localparam int TOUT  = 4;
    localparam int CMAX  = 15;

    // Control bits packed as {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_write, mem_wb_bubble}.
    localparam logic [5:0] FRZ = 6'b000001;
    localparam logic [5:0] NRM = 6'b110010;
    localparam logic [5:0] LU  = 6'b000110;
    localparam logic [5:0] BR  = 6'b111010;

    typedef struct packed {
        logic             start;
        logic             memread;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic             br;
        logic             req;
        logic             rdy;
    } in_t;

    typedef struct packed {
        in_t        stim;
        logic [5:0] ctrl;
        logic       tout;
        logic [3:0] cnt;
    } vec_t;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             start_i = 1'b0;
    logic             ex_memread_i = 1'b0;
    logic [REG_W-1:0] ex_rd_i = '0;
    logic [REG_W-1:0] id_rs1_i = '0;
    logic [REG_W-1:0] id_rs2_i = '0;
    logic             id_br_taken_i = 1'b0;
    logic             mem_req_i = 1'b0;
    logic             mem_ready_i = 1'b0;
    logic             pc_write_o;
    logic             if_id_write_o;
    logic             if_id_flush_o;
    logic             id_ex_bubble_o;
    logic             ex_mem_write_o;
    logic             mem_wb_bubble_o;
    logic             mem_timeout_o;
    logic [CNT_W-1:0] stall_cnt_o;

    int checks = 0;
    int errors = 0;

    // Reference model state: 0 idle, 1 running, 2 waiting on memory, 3 trapped.
    int m_mode;
    int m_waited;
    int m_stalls;
    bit m_tout;

    vec_t vecs [19];

    always #5 clk_i = ~clk_i;

    pipeline_stall_controller #(
        .REG_W       (REG_W),
        .CNT_W       (CNT_W),
        .MEM_TIMEOUT (TOUT)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .ex_memread_i    (ex_memread_i),
        .ex_rd_i         (ex_rd_i),
        .id_rs1_i        (id_rs1_i),
        .id_rs2_i        (id_rs2_i),
        .id_br_taken_i   (id_br_taken_i),
        .mem_req_i       (mem_req_i),
        .mem_ready_i     (mem_ready_i),
        .pc_write_o      (pc_write_o),
        .if_id_write_o   (if_id_write_o),
        .if_id_flush_o   (if_id_flush_o),
        .id_ex_bubble_o  (id_ex_bubble_o),
        .ex_mem_write_o  (ex_mem_write_o),
        .mem_wb_bubble_o (mem_wb_bubble_o),
        .mem_timeout_o   (mem_timeout_o),
        .stall_cnt_o     (stall_cnt_o)
    );

    function automatic in_t mk(input logic st, input logic mr, input logic [REG_W-1:0] rd,
                               input logic [REG_W-1:0] rs1, input logic [REG_W-1:0] rs2,
                               input logic br, input logic rq, input logic ry);
        in_t v;
        v.start = st; v.memread = mr; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.br = br; v.req = rq; v.rdy = ry;
        return v;
    endfunction

    function automatic vec_t mkv(input in_t s, input logic [5:0] c, input logic t, input logic [3:0] n);
        vec_t v;
        v.stim = s; v.ctrl = c; v.tout = t; v.cnt = n;
        return v;
    endfunction

    function automatic logic [5:0] act_ctrl();
        return {pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o, ex_mem_write_o, mem_wb_bubble_o};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [5:0] c, input logic t, input int n);
        check({name, ".ctrl"}, 32'(act_ctrl()), 32'(c));
        check({name, ".tout"}, 32'(mem_timeout_o), 32'(t));
        check({name, ".cnt"}, 32'(stall_cnt_o), 32'(n));
    endtask

    task automatic drive(input in_t v);
        start_i       = v.start;
        ex_memread_i  = v.memread;
        ex_rd_i       = v.rd;
        id_rs1_i      = v.rs1;
        id_rs2_i      = v.rs2;
        id_br_taken_i = v.br;
        mem_req_i     = v.req;
        mem_ready_i   = v.rdy;
    endtask

    // Apply one cycle of stimulus; returns at the falling edge, ready for sampling.
    task automatic step(input in_t v);
        @(posedge clk_i);
        #1;
        drive(v);
        @(negedge clk_i);
    endtask

    task automatic model_reset();
        m_mode = 0; m_waited = 0; m_stalls = 0; m_tout = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        drive('0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        model_reset();
    endtask

    // Expected controls derived straight from the priority rules.
    function automatic logic [5:0] model_ctrl(input in_t v);
        bit hazard;
        hazard = v.memread && (v.rd != 0) && ((v.rd == v.rs1) || (v.rd == v.rs2));
        if (m_mode == 1) begin
            if (v.req && !v.rdy) return FRZ;
            if (hazard)          return LU;
            if (v.br)            return BR;
            return NRM;
        end
        if (m_mode == 2) return v.rdy ? NRM : FRZ;
        return FRZ;
    endfunction

    task automatic model_tick(input in_t v, input logic [5:0] c);
        if ((m_mode == 1 || m_mode == 2) && !c[5]) m_stalls = (m_stalls < CMAX) ? m_stalls + 1 : CMAX;
        if (m_mode == 0) begin
            if (v.start) m_mode = 1;
        end else if (m_mode == 1) begin
            if (v.req && !v.rdy) begin m_mode = 2; m_waited = 1; end
        end else if (m_mode == 2) begin
            if (v.rdy) begin
                m_mode = 1; m_waited = 0;
            end else if (m_waited >= TOUT) begin
                m_mode = 3; m_tout = 1'b1;
            end else begin
                m_waited++;
            end
        end
    endtask

    initial begin
        in_t  v;
        logic [5:0] ec;
        int   rdy_pct;

        // Directed table: reset idle, start, load-use, x0, branch, wait, release, ignored start.
        for (int i = 0; i < 5; i++) vecs[i] = mkv(mk(0, 0, 0, 0, 0, 0, 0, 0), FRZ, 0, 0);
        vecs[5]  = mkv(mk(1, 0, 0, 0, 0, 0, 0, 0), FRZ, 0, 0);
        vecs[6]  = mkv(mk(0, 0, 0, 0, 0, 0, 0, 0), NRM, 0, 0);
        vecs[7]  = mkv(mk(0, 1, 5, 1, 5, 0, 0, 0), LU,  0, 0);
        vecs[8]  = mkv(mk(0, 0, 0, 0, 0, 0, 0, 0), NRM, 0, 1);
        vecs[9]  = mkv(mk(0, 1, 0, 0, 0, 0, 0, 0), NRM, 0, 1);
        vecs[10] = mkv(mk(0, 1, 3, 3, 7, 1, 0, 0), LU,  0, 1);
        vecs[11] = mkv(mk(0, 0, 0, 0, 0, 1, 0, 0), BR,  0, 2);
        vecs[12] = mkv(mk(0, 1, 3, 3, 0, 1, 1, 0), FRZ, 0, 2);
        vecs[13] = mkv(mk(0, 0, 0, 0, 0, 1, 1, 0), FRZ, 0, 3);
        vecs[14] = mkv(mk(0, 0, 0, 0, 0, 0, 0, 0), FRZ, 0, 4);
        vecs[15] = mkv(mk(0, 1, 3, 3, 0, 1, 1, 1), NRM, 0, 5);
        vecs[16] = mkv(mk(0, 0, 0, 0, 0, 0, 0, 0), NRM, 0, 5);
        vecs[17] = mkv(mk(0, 0, 0, 0, 0, 0, 1, 1), NRM, 0, 5);
        vecs[18] = mkv(mk(1, 0, 0, 0, 0, 0, 0, 0), NRM, 0, 5);

        model_reset();
        #2;
        check_all("in_reset", FRZ, 1'b0, 0);
        do_reset();

        for (int i = 0; i < 19; i++) begin
            step(vecs[i].stim);
            check_all($sformatf("vec%0d", i), vecs[i].ctrl, vecs[i].tout, int'(vecs[i].cnt));
        end

        // Hung memory: RUN freeze, four wait edges, then sticky error.
        do_reset();
        step(mk(1, 0, 0, 0, 0, 0, 0, 0));
        step(mk(0, 0, 0, 0, 0, 0, 1, 0));
        check_all("tmo_enter", FRZ, 1'b0, 0);
        for (int i = 1; i <= 4; i++) begin
            step(mk(0, 0, 0, 0, 0, 0, 1, 0));
            check_all($sformatf("tmo_wait%0d", i), FRZ, 1'b0, i);
        end
        step(mk(0, 0, 0, 0, 0, 0, 1, 0));
        check_all("tmo_error", FRZ, 1'b1, 5);
        for (int i = 0; i < 3; i++) begin
            step(mk(1, 0, 0, 0, 0, 1, 1, 1));
            check_all($sformatf("tmo_sticky%0d", i), FRZ, 1'b1, 5);
        end
        rst_i = 1'b1;
        #1;
        check_all("tmo_async_rst", FRZ, 1'b0, 0);

        // Reset in the middle of a memory wait must land in IDLE, not back in the wait.
        do_reset();
        step(mk(1, 0, 0, 0, 0, 0, 0, 0));
        step(mk(0, 0, 0, 0, 0, 0, 1, 0));
        step(mk(0, 0, 0, 0, 0, 0, 1, 0));
        check_all("mw_before_rst", FRZ, 1'b0, 1);
        rst_i = 1'b1;
        #1;
        check_all("mw_async_rst", FRZ, 1'b0, 0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        step(mk(0, 0, 0, 0, 0, 0, 1, 1));
        check_all("mw_rst_idle", FRZ, 1'b0, 0);

        // Saturation: 20 load-use stalls on a 4-bit counter.
        do_reset();
        step(mk(1, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 20; i++) begin
            step(mk(0, 1, 9, 9, 2, 0, 0, 0));
            if (i == 0 || i == 19) check($sformatf("sat_lu%0d", i), 32'(act_ctrl()), 32'(LU));
        end
        step(mk(0, 0, 0, 0, 0, 0, 0, 0));
        check_all("sat_final", NRM, 1'b0, CMAX);

        // Random traffic against the reference model, with shifting memory latency.
        do_reset();
        rdy_pct = 60;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 250 == 0) begin
                case ((cyc / 250) % 3)
                    0:       rdy_pct = 60;
                    1:       rdy_pct = 15;
                    default: rdy_pct = 0;
                endcase
            end
            if ($urandom_range(0, 119) == 0) do_reset();
            v.start   = ($urandom_range(0, 7) == 0);
            v.memread = $urandom_range(0, 1);
            v.rd      = REG_W'($urandom_range(0, 3));
            v.rs1     = REG_W'($urandom_range(0, 3));
            v.rs2     = REG_W'($urandom_range(0, 3));
            v.br      = ($urandom_range(0, 3) == 0);
            v.req     = ($urandom_range(0, 2) == 0);
            v.rdy     = ($urandom_range(0, 99) < rdy_pct);
            step(v);
            ec = model_ctrl(v);
            check_all($sformatf("rand%0d", cyc), ec, m_tout, m_stalls);
            model_tick(v, ec);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
